conv_result_framer: RTL and testbench
=====================================

// Module: conv_result_framer
// PURPOSE
// Receive end of the convolution pixel stream: sink for conv data_out/data_out_en.
// Tags each result with raster position (sof/eol/eof), buffers it in a small FIFO and
// re-emits it on a ready/valid master stream to the frame writer / display path.
// Upstream has no backpressure; the FIFO absorbs stalls and flags overflow.
// PARAMETERS
// DATA_W      16   result word width (matches conv data_out)
// COLS        478  results per output line (input line width 480 minus 2)
// ROWS        270  output lines per frame
// FIFO_DEPTH  16   buffer entries, power of 2, >= 4
// PORTS
// clk         in   1       pixel clock
// rst         in   1       asynchronous reset, active-high
// data_in     in   DATA_W  conv result word
// data_in_en  in   1       data_in valid this cycle (no backpressure)
// frame_sync  in   1       pulse: abandon current frame position, next word is sof
// clr_ovf     in   1       pulse: clear sticky overflow
// m_data      out  DATA_W  output word
// m_valid     out  1       m_data/flags valid
// m_ready     in   1       downstream accepts when m_valid && m_ready
// m_sof       out  1       word is col 0, row 0
// m_eol       out  1       word is col COLS-1
// m_eof       out  1       word is col COLS-1, row ROWS-1
// overflow    out  1       sticky: a word was dropped because FIFO full
// frame_cnt   out  16      completed frames (eof words written), wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async, rst=1): all outputs 0, FIFO empty, col=row=0, state IDLE.
// - Write-side FSM: IDLE -> ACTIVE on first data_in_en (that word tagged sof);
//   ACTIVE -> IDLE after the eof word is written; frame_sync in any state -> IDLE,
//   col=row=0 same cycle (if data_in_en also high, that word is sof of new frame).
// - Counters: col increments per data_in_en; at COLS-1 wraps to 0 and row++;
//   at row ROWS-1/col COLS-1 both wrap to 0, frame_cnt++.
// - Counters advance on every data_in_en even when word is dropped: raster
//   alignment preserved, dropped word simply missing from output.
// - FIFO entry = {sof,eol,eof,data}, DATA_W+3 bits; first-word-fall-through.
// - Latency: word written at edge N appears on m_* after edge N (m_valid high in
//   cycle N+1) when FIFO was empty; pop on m_valid && m_ready at the same edge.
// - Push accepted if !full, or if full and a pop happens in the same cycle.
// - Full and no pop: word dropped, overflow<=1; overflow holds until clr_ovf or rst;
//   clr_ovf and a new drop in same cycle -> overflow stays 1.
// - Empty: m_valid=0; m_data/flags hold last value (don't-care for checker).
// - m_data/flags stable while m_valid && !m_ready.
// - Pointers wrap modulo FIFO_DEPTH; occupancy count range 0..FIFO_DEPTH.
// - rst mid-frame: FIFO contents discarded, frame_cnt and overflow cleared.
// TESTING
// - COLS=4,ROWS=2, 8 words 1..8, m_ready=1 -> 8 outputs 1 cycle late, sof on 1,
//   eol on 4 and 8, eof on 8, frame_cnt=1.
// - m_ready=0 for 20 words, DEPTH=16 -> 16 stored, overflow=1, then m_ready=1
//   drains words 1..16 in order; next frame sof position unchanged.
// - Full FIFO, m_ready=1 and data_in_en same cycle -> no drop, overflow stays 0.
// - frame_sync after 3 words of a 4x2 frame, then word 0xA -> 0xA tagged sof,
//   frame_cnt unchanged.
// - rst asserted with 5 words buffered -> m_valid=0 asynchronously, overflow=0,
//   frame_cnt=0; next word tagged sof.
// - Random m_ready (50%) over 3 frames COLS=478,ROWS=3 at full input rate with
//   DEPTH=16 -> scoreboard: outputs are in-order subset, flags match position.

Source files
------------

// File: rtl/conv_result_framer_if.sv
// Output stream of the convolution result framer: one tagged word per
// m_valid && m_ready handshake, raster flags travel alongside the data.
interface conv_result_framer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;

    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/conv_result_framer.sv
// Receive end of the convolution pixel stream. Each incoming result is tagged
// with its raster position (sof/eol/eof), buffered in a small FIFO and replayed
// on a ready/valid stream. The producer cannot be stalled, so a full FIFO drops
// the word and raises a sticky overflow flag; raster counters keep advancing so
// later words still carry the right position.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the first word of a frame (next word is sof)
// ACTIVE | inside a frame, counting columns and rows
module conv_result_framer #(
    parameter int DATA_W     = 16,
    parameter int COLS       = 478,
    parameter int ROWS       = 270,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      data_in_en,
    input  logic                      frame_sync,
    input  logic                      clr_ovf,
    conv_result_framer_if.master      m,
    output logic                      overflow,
    output logic [15:0]               frame_cnt
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

    logic [COL_W-1:0]   pos_col;
    logic [ROW_W-1:0]   pos_row;
    logic               tag_sof, tag_eol, tag_eof;
    logic [ENT_W-1:0]   wr_entry;
    logic               full, pop, push, drop;
    logic [CNT_W-1:0]   count_after_pop;

    // Raster position of the incoming word; frame_sync restarts it at 0,0 this cycle.
    always_comb begin
        pos_col  = frame_sync ? '0 : col_q;
        pos_row  = frame_sync ? '0 : row_q;
        tag_sof  = (pos_col == '0) && (pos_row == '0);
        tag_eol  = (pos_col == COL_W'(COLS - 1));
        tag_eof  = tag_eol && (pos_row == ROW_W'(ROWS - 1));
        wr_entry = {tag_sof, tag_eol, tag_eof, data_in};
    end

    // FIFO handshake: a full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        full            = (count_q == CNT_W'(FIFO_DEPTH));
        pop             = out_valid_q && m.m_ready;
        push            = data_in_en && (!full || pop);
        drop            = data_in_en && full && !pop;
        count_after_pop = pop ? (count_q - CNT_W'(1)) : count_q;
        count_d         = push ? (count_after_pop + CNT_W'(1)) : count_after_pop;
        wr_ptr_d        = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d        = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        out_valid_d     = (count_d != '0);
        // Output register mirrors the next head; a word entering an emptied FIFO bypasses memory.
        out_d = out_q;
        if (count_after_pop != '0) begin
            out_d = mem_q[rd_ptr_d];
        end else if (push) begin
            out_d = wr_entry;
        end
    end

    // Frame FSM, raster counters, frame count and sticky overflow.
    always_comb begin
        state_d     = frame_sync ? IDLE : state_q;
        col_d       = pos_col;
        row_d       = pos_row;
        frame_cnt_d = frame_cnt_q;
        if (data_in_en) begin
            state_d = ACTIVE;
            if (tag_eol) begin
                col_d = '0;
                if (tag_eof) begin
                    row_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end else begin
                    row_d = pos_row + ROW_W'(1);
                end
            end else begin
                col_d = pos_col + COL_W'(1);
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign m.m_valid = out_valid_q;
    assign m.m_sof   = out_q[ENT_W-1];
    assign m.m_eol   = out_q[ENT_W-2];
    assign m.m_eof   = out_q[ENT_W-3];
    assign m.m_data  = out_q[DATA_W-1:0];
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_conv_result_framer.sv
// Bench for conv_result_framer: a 4x2 instance for directed sequences and a
// 478x3 instance for a random-backpressure run, both scored every cycle
// against a cycle model of the framer.
module tb_conv_result_framer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] a_data, b_data;
    logic        a_en, a_sync, a_clr, b_en, b_sync, b_clr;
    logic        a_ovf, b_ovf;
    logic [15:0] a_fcnt, b_fcnt;

    conv_result_framer_if #(.DATA_W(16)) a_if ();
    conv_result_framer_if #(.DATA_W(16)) b_if ();

    conv_result_framer #(.DATA_W(16), .COLS(4), .ROWS(2), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst), .data_in(a_data), .data_in_en(a_en), .frame_sync(a_sync),
        .clr_ovf(a_clr), .m(a_if), .overflow(a_ovf), .frame_cnt(a_fcnt)
    );

    conv_result_framer #(.DATA_W(16), .COLS(478), .ROWS(3), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .data_in(b_data), .data_in_en(b_en), .frame_sync(b_sync),
        .clr_ovf(b_clr), .m(b_if), .overflow(b_ovf), .frame_cnt(b_fcnt)
    );

    logic [18:0] a_out, b_out;
    assign a_out = {a_if.m_sof, a_if.m_eol, a_if.m_eof, a_if.m_data};
    assign b_out = {b_if.m_sof, b_if.m_eol, b_if.m_eof, b_if.m_data};

    int checks   = 0;
    int failures = 0;

    // Cycle model state, index 0 = instance a, 1 = instance b.
    int          mcol [2];
    int          mrow [2];
    logic [15:0] mfcnt [2];
    logic        movf [2];
    logic [18:0] mq0 [$];
    logic [18:0] mq1 [$];

    typedef struct {
        logic        en;
        logic [15:0] data;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [2:0]  exp_flags;
        logic [15:0] exp_fcnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int mcols(input int id);
        return (id == 0) ? 4 : 478;
    endfunction

    function automatic int mrows(input int id);
        return (id == 0) ? 2 : 3;
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [18:0] qfront(input int id);
        return (id == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic qpop(input int id);
        if (id == 0) void'(mq0.pop_front());
        else         void'(mq1.pop_front());
    endtask

    task automatic qpush(input int id, input logic [18:0] v);
        if (id == 0) mq0.push_back(v);
        else         mq1.push_back(v);
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            mcol[id]  = 0;
            mrow[id]  = 0;
            mfcnt[id] = '0;
            movf[id]  = 1'b0;
        end
        mq0.delete();
        mq1.delete();
    endtask

    task automatic model_update(input int id, input logic en, input logic [15:0] d,
                                input logic sync, input logic clr, input logic rdy);
        int sz;
        bit pop, drop, sof, eol, eof;
        int c, r;
        sz   = qsize(id);
        pop  = (sz > 0) && rdy;
        c    = sync ? 0 : mcol[id];
        r    = sync ? 0 : mrow[id];
        drop = 1'b0;
        if (pop) qpop(id);
        if (en) begin
            sof = (c == 0) && (r == 0);
            eol = (c == mcols(id) - 1);
            eof = eol && (r == mrows(id) - 1);
            if (sz == DEPTH && !pop) drop = 1'b1;
            else qpush(id, {sof, eol, eof, d});
            if (eol) begin
                c = 0;
                if (eof) begin
                    r = 0;
                    mfcnt[id] = mfcnt[id] + 16'd1;
                end else begin
                    r = r + 1;
                end
            end else begin
                c = c + 1;
            end
        end
        mcol[id] = c;
        mrow[id] = r;
        if (drop)     movf[id] = 1'b1;
        else if (clr) movf[id] = 1'b0;
    endtask

    task automatic model_check();
        logic        v, o;
        logic [18:0] e;
        logic [15:0] f;
        for (int id = 0; id < 2; id++) begin
            v = (id == 0) ? a_if.m_valid : b_if.m_valid;
            e = (id == 0) ? a_out : b_out;
            o = (id == 0) ? a_ovf : b_ovf;
            f = (id == 0) ? a_fcnt : b_fcnt;
            chk($sformatf("d%0d m_valid", id), 32'(v), 32'(qsize(id) > 0));
            if (qsize(id) > 0) chk($sformatf("d%0d entry", id), 32'(e), 32'(qfront(id)));
            chk($sformatf("d%0d overflow", id), 32'(o), 32'(movf[id]));
            chk($sformatf("d%0d frame_cnt", id), 32'(f), 32'(mfcnt[id]));
        end
    endtask

    // One clock: score outputs at the negedge, drive inputs, advance the model, return at posedge+1.
    task automatic tick(input logic ae, input logic [15:0] ad, input logic as, input logic ac,
                        input logic ar, input logic be, input logic [15:0] bd, input logic br);
        @(negedge clk);
        model_check();
        a_en = ae; a_data = ad; a_sync = as; a_clr = ac; a_if.m_ready = ar;
        b_en = be; b_data = bd; b_sync = 1'b0; b_clr = 1'b0; b_if.m_ready = br;
        model_update(0, ae, ad, as, ac, ar);
        model_update(1, be, bd, 1'b0, 1'b0, br);
        @(posedge clk);
        #1;
    endtask

    task automatic ta(input logic en, input logic [15:0] d, input logic sync,
                      input logic clr, input logic rdy);
        tick(en, d, sync, clr, rdy, 1'b0, 16'h0, 1'b1);
    endtask

    function automatic vec_t mkvec(input logic en, input logic [15:0] d, input logic rdy,
                                   input logic ev, input logic [15:0] ed,
                                   input logic [2:0] ef, input logic [15:0] fc);
        vec_t v;
        v.en = en; v.data = d; v.rdy = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_flags = ef; v.exp_fcnt = fc;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] saved_fcnt;

        // Expected state after each edge of a 4x2 frame, words 1..8, downstream always ready.
        vecs[0] = mkvec(1'b1, 16'd1, 1'b1, 1'b1, 16'd1, 3'b100, 16'd0);
        vecs[1] = mkvec(1'b1, 16'd2, 1'b1, 1'b1, 16'd2, 3'b000, 16'd0);
        vecs[2] = mkvec(1'b1, 16'd3, 1'b1, 1'b1, 16'd3, 3'b000, 16'd0);
        vecs[3] = mkvec(1'b1, 16'd4, 1'b1, 1'b1, 16'd4, 3'b010, 16'd0);
        vecs[4] = mkvec(1'b1, 16'd5, 1'b1, 1'b1, 16'd5, 3'b000, 16'd0);
        vecs[5] = mkvec(1'b1, 16'd6, 1'b1, 1'b1, 16'd6, 3'b000, 16'd0);
        vecs[6] = mkvec(1'b1, 16'd7, 1'b1, 1'b1, 16'd7, 3'b000, 16'd0);
        vecs[7] = mkvec(1'b1, 16'd8, 1'b1, 1'b1, 16'd8, 3'b011, 16'd1);
        vecs[8] = mkvec(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 3'b000, 16'd1);

        rst = 1'b1;
        a_en = 1'b0; a_data = '0; a_sync = 1'b0; a_clr = 1'b0; a_if.m_ready = 1'b0;
        b_en = 1'b0; b_data = '0; b_sync = 1'b0; b_clr = 1'b0; b_if.m_ready = 1'b0;
        model_reset();

        @(posedge clk);
        #1;
        chk("reset m_valid", 32'(a_if.m_valid), 32'd0);
        chk("reset m_out", 32'(a_out), 32'd0);
        chk("reset overflow", 32'(a_ovf), 32'd0);
        chk("reset frame_cnt", 32'(a_fcnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 4x2 frame.
        for (int i = 0; i < 9; i++) begin
            ta(vecs[i].en, vecs[i].data, 1'b0, 1'b0, vecs[i].rdy);
            chk($sformatf("vec%0d m_valid", i), 32'(a_if.m_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d m_data", i), 32'(a_if.m_data), 32'(vecs[i].exp_data));
                chk($sformatf("vec%0d flags", i), 32'({a_if.m_sof, a_if.m_eol, a_if.m_eof}),
                    32'(vecs[i].exp_flags));
            end
            chk($sformatf("vec%0d frame_cnt", i), 32'(a_fcnt), 32'(vecs[i].exp_fcnt));
        end

        // Stalled downstream: 20 words, 16 kept, overflow set, drained in order.
        for (int i = 1; i <= 20; i++) ta(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("stall overflow", 32'(a_ovf), 32'd1);
        chk("stall head", 32'(a_if.m_data), 32'd1);
        for (int i = 0; i < 16; i++) ta(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("stall drained", 32'(a_if.m_valid), 32'd0);

        // Drop and clear in the same cycle keeps overflow; clear alone releases it.
        for (int i = 0; i < 16; i++) ta(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
        ta(1'b1, 16'h1ff, 1'b0, 1'b1, 1'b0);
        chk("clr+drop overflow", 32'(a_ovf), 32'd1);
        ta(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("clr overflow", 32'(a_ovf), 32'd0);

        // Full FIFO with a simultaneous pop accepts the new word.
        ta(1'b1, 16'h77, 1'b0, 1'b0, 1'b1);
        chk("full+pop overflow", 32'(a_ovf), 32'd0);
        chk("full+pop valid", 32'(a_if.m_valid), 32'd1);
        for (int i = 0; i < 17; i++) ta(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // frame_sync mid-frame restarts raster position.
        ta(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        saved_fcnt = mfcnt[0];
        ta(1'b1, 16'h1, 1'b0, 1'b0, 1'b1);
        ta(1'b1, 16'h2, 1'b0, 1'b0, 1'b1);
        ta(1'b1, 16'h3, 1'b0, 1'b0, 1'b1);
        ta(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        ta(1'b1, 16'hA, 1'b0, 1'b0, 1'b1);
        chk("sync word data", 32'(a_if.m_data), 32'hA);
        chk("sync word sof", 32'(a_if.m_sof), 32'd1);
        chk("sync frame_cnt", 32'(a_fcnt), 32'(saved_fcnt));
        ta(1'b1, 16'hB, 1'b1, 1'b0, 1'b1);
        chk("sync+en data", 32'(a_if.m_data), 32'hB);
        chk("sync+en sof", 32'(a_if.m_sof), 32'd1);
        ta(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        ta(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Async reset with words buffered and overflow set.
        for (int i = 0; i < 17; i++) ta(1'b1, 16'(16'h200 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) ta(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("pre-reset valid", 32'(a_if.m_valid), 32'd1);
        chk("pre-reset overflow", 32'(a_ovf), 32'd1);
        a_if.m_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst m_valid", 32'(a_if.m_valid), 32'd0);
        chk("async rst overflow", 32'(a_ovf), 32'd0);
        chk("async rst frame_cnt", 32'(a_fcnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ta(1'b1, 16'h55, 1'b0, 1'b0, 1'b1);
        chk("post-rst data", 32'(a_if.m_data), 32'h55);
        chk("post-rst sof", 32'(a_if.m_sof), 32'd1);
        ta(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Three 478x3 frames at full rate with random backpressure.
        for (int i = 0; i < 478 * 3 * 3; i++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1,
                 1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("rand frame_cnt", 32'(b_fcnt), 32'd3);
        chk("rand drained", 32'(b_if.m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
